// File: rtl/cdb_arbiter.sv
// cdb_arbiter
//   Arbitrates three functional units (0=ALU, 1=MUL, 2=LOAD) onto a single
//   common data bus. One requester is granted per cycle in round-robin order,
//   and the granted result is broadcast on the registered BC* outputs in the
//   following cycle.
//
// Ports
//   clk                  single clock, rising edge
//   RST                  synchronous active-high reset
//   req[2:0]             per-unit "result pending"
//   label0..2            result tag {station id + 1, slot}; 0 = no tag
//   data0..2             result value
//   gnt[2:0]             combinational one-hot grant (0 when idle or in RST)
//   BCEN                 registered broadcast enable
//   BClabel / BCdata     registered broadcast tag / value
//   tag_err              registered pulse: granted request carried label 0
//   bc_count[15:0]       registered count of broadcasts issued (wraps)
module cdb_arbiter #(
    parameter int DATA_W  = 32,
    parameter int LABEL_W = 4
) (
    input  logic               clk,
    input  logic               RST,
    input  logic [2:0]         req,
    input  logic [LABEL_W-1:0] label0,
    input  logic [LABEL_W-1:0] label1,
    input  logic [LABEL_W-1:0] label2,
    input  logic [DATA_W-1:0]  data0,
    input  logic [DATA_W-1:0]  data1,
    input  logic [DATA_W-1:0]  data2,
    output logic [2:0]         gnt,
    output logic               BCEN,
    output logic [LABEL_W-1:0] BClabel,
    output logic [DATA_W-1:0]  BCdata,
    output logic               tag_err,
    output logic [15:0]        bc_count
);

    logic [1:0]               rr_ptr_q, rr_ptr_d;
    logic                     bcen_q, bcen_d;
    logic [LABEL_W-1:0]       label_q, label_d;
    logic [DATA_W-1:0]        data_q, data_d;
    logic                     terr_q, terr_d;
    logic [15:0]              cnt_q, cnt_d;

    logic [2:0]               gnt_c;
    logic [1:0]               sel;
    logic                     found;
    logic [1:0]               ord [0:2];
    logic [2:0][LABEL_W-1:0]  lbl_arr;
    logic [2:0][DATA_W-1:0]   dat_arr;

    assign lbl_arr = {label2, label1, label0};
    assign dat_arr = {data2, data1, data0};

    // Search order rotated to start at the round-robin pointer. Pointer value
    // 3 never occurs; it falls back to the natural order.
    always_comb begin
        ord[0] = 2'd0;
        ord[1] = 2'd1;
        ord[2] = 2'd2;
        case (rr_ptr_q)
            2'd1: begin ord[0] = 2'd1; ord[1] = 2'd2; ord[2] = 2'd0; end
            2'd2: begin ord[0] = 2'd2; ord[1] = 2'd0; ord[2] = 2'd1; end
            default: ;
        endcase
    end

    // First requester in rotated order wins; reset suppresses every grant.
    always_comb begin
        gnt_c = '0;
        sel   = 2'd0;
        found = 1'b0;
        if (!RST) begin
            for (int k = 0; k < 3; k++) begin
                if (!found && req[ord[k]]) begin
                    gnt_c[ord[k]] = 1'b1;
                    sel           = ord[k];
                    found         = 1'b1;
                end
            end
        end
    end

    assign gnt = gnt_c;

    always_comb begin
        rr_ptr_d = rr_ptr_q;
        bcen_d   = 1'b0;
        label_d  = label_q;
        data_d   = data_q;
        terr_d   = 1'b0;
        cnt_d    = cnt_q;
        if (found) begin
            rr_ptr_d = (sel == 2'd2) ? 2'd0 : sel + 2'd1;
            if (lbl_arr[sel] != '0) begin
                bcen_d  = 1'b1;
                label_d = lbl_arr[sel];
                data_d  = dat_arr[sel];
                cnt_d   = cnt_q + 16'd1;
            end else begin
                // Untagged result is consumed but never broadcast.
                terr_d = 1'b1;
            end
        end
    end

    always_ff @(posedge clk) begin
        if (RST) begin
            rr_ptr_q <= 2'd0;
            bcen_q   <= 1'b0;
            label_q  <= '0;
            data_q   <= '0;
            terr_q   <= 1'b0;
            cnt_q    <= 16'd0;
        end else begin
            rr_ptr_q <= rr_ptr_d;
            bcen_q   <= bcen_d;
            label_q  <= label_d;
            data_q   <= data_d;
            terr_q   <= terr_d;
            cnt_q    <= cnt_d;
        end
    end

    assign BCEN     = bcen_q;
    assign BClabel  = label_q;
    assign BCdata   = data_q;
    assign tag_err  = terr_q;
    assign bc_count = cnt_q;

endmodule

// File: tb/tb_cdb_arbiter.sv
// tb_cdb_arbiter
//   Directed and randomized checks of cdb_arbiter against a round-robin
//   reference model kept in the bench.
module tb_cdb_arbiter;

    logic        clk = 1'b0;
    logic        RST = 1'b1;
    logic [2:0]  req = '0;
    logic [3:0]  label0 = '0, label1 = '0, label2 = '0;
    logic [31:0] data0 = '0, data1 = '0, data2 = '0;
    logic [2:0]  gnt;
    logic        BCEN;
    logic [3:0]  BClabel;
    logic [31:0] BCdata;
    logic        tag_err;
    logic [15:0] bc_count;

    cdb_arbiter #(.DATA_W(32), .LABEL_W(4)) dut (
        .clk(clk), .RST(RST), .req(req),
        .label0(label0), .label1(label1), .label2(label2),
        .data0(data0), .data1(data1), .data2(data2),
        .gnt(gnt), .BCEN(BCEN), .BClabel(BClabel), .BCdata(BCdata),
        .tag_err(tag_err), .bc_count(bc_count)
    );

    always #5 clk = ~clk;

    int checks = 0;
    int errors = 0;

    // reference model state
    int          m_ptr;
    bit          m_bcen;
    logic [3:0]  m_label;
    logic [31:0] m_data;
    bit          m_terr;
    logic [15:0] m_cnt;
    int          last_g;
    int          dwait [3];
    bit          chk_starve;

    task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
        end
    endtask

    function automatic int pick(input logic [2:0] r, input int p);
        for (int k = 0; k < 3; k++)
            if (r[(p + k) % 3]) return (p + k) % 3;
        return -1;
    endfunction

    function automatic logic [3:0] lab_of(input int i);
        return (i == 0) ? label0 : (i == 1) ? label1 : label2;
    endfunction

    function automatic logic [31:0] dat_of(input int i);
        return (i == 0) ? data0 : (i == 1) ? data1 : data2;
    endfunction

    // One cycle: inputs already applied; check gnt mid-cycle, then the
    // registered outputs just after the edge.
    task automatic cyc(input bit rst);
        int g;
        logic [2:0] eg;
        RST = rst;
        @(negedge clk);
        g  = rst ? -1 : pick(req, m_ptr);
        eg = (g < 0) ? 3'b000 : 3'(1 << g);
        chk("gnt", 64'(gnt), 64'(eg));
        if (chk_starve) begin
            for (int i = 0; i < 3; i++) begin
                if (req[i] && !gnt[i]) dwait[i]++;
                else dwait[i] = 0;
                chk("starve", 64'(dwait[i] <= 2), 64'd1);
            end
        end
        @(posedge clk);
        if (rst) begin
            m_ptr = 0; m_bcen = 0; m_label = 0; m_data = 0; m_terr = 0; m_cnt = 0;
        end else if (g >= 0) begin
            m_ptr = (g + 1) % 3;
            if (lab_of(g) != 0) begin
                m_bcen = 1; m_terr = 0;
                m_label = lab_of(g); m_data = dat_of(g);
                m_cnt = m_cnt + 16'd1;
            end else begin
                m_bcen = 0; m_terr = 1;
            end
        end else begin
            m_bcen = 0; m_terr = 0;
        end
        last_g = g;
        #1;
        chk("BCEN", 64'(BCEN), 64'(m_bcen));
        chk("BClabel", 64'(BClabel), 64'(m_label));
        chk("BCdata", 64'(BCdata), 64'(m_data));
        chk("tag_err", 64'(tag_err), 64'(m_terr));
        chk("bc_count", 64'(bc_count), 64'(m_cnt));
    endtask

    initial begin
        bit [2:0] pend;
        chk_starve = 0;
        for (int i = 0; i < 3; i++) dwait[i] = 0;

        // reset state
        req = 3'b111; label0 = 4'h1; label1 = 4'h2; label2 = 4'h3;
        cyc(1);
        chk("rst_BCEN", 64'(BCEN), 64'd0);
        chk("rst_cnt", 64'(bc_count), 64'd0);

        // single requester
        req = 3'b001; label0 = 4'h5; data0 = 32'hDEAD_BEEF;
        cyc(0);
        chk("single_gnt", 64'(last_g), 64'd0);
        chk("single_data", 64'(BCdata), 64'hDEAD_BEEF);
        chk("single_cnt", 64'(bc_count), 64'd1);

        // contention from reset: 001, 010, 100, 001
        req = '0; cyc(1);
        req = 3'b111; label0 = 4'h4; label1 = 4'h8; label2 = 4'hC;
        data0 = 32'h1111_0000; data1 = 32'h2222_0000; data2 = 32'h3333_0000;
        cyc(0); chk("cont0", 64'(last_g), 64'd0);
        cyc(0); chk("cont1", 64'(last_g), 64'd1);
        cyc(0); chk("cont2", 64'(last_g), 64'd2);
        cyc(0); chk("cont3", 64'(last_g), 64'd0);
        chk("cont_cnt", 64'(bc_count), 64'd4);

        // pointer skip: ptr 1, only req0 -> ptr stays 1, then 011 -> 010
        req = '0; cyc(1);
        req = 3'b001; cyc(0);
        req = 3'b001; cyc(0); chk("skip_a", 64'(last_g), 64'd0);
        req = 3'b011; cyc(0); chk("skip_b", 64'(last_g), 64'd1);

        // zero tag from LOAD
        req = 3'b100; label2 = 4'h0; data2 = 32'hBAD0_BAD0;
        cyc(0);
        chk("ztag_gnt", 64'(last_g), 64'd2);
        chk("ztag_err", 64'(tag_err), 64'd1);
        chk("ztag_bcen", 64'(BCEN), 64'd0);
        req = '0; cyc(0);
        chk("ztag_clr", 64'(tag_err), 64'd0);

        // reset mid-stream
        req = 3'b111; label2 = 4'h9;
        cyc(0); cyc(0);
        cyc(1);
        chk("rms_bcen", 64'(BCEN), 64'd0);
        chk("rms_cnt", 64'(bc_count), 64'd0);
        cyc(0);
        chk("rms_first", 64'(last_g), 64'd0);

        // randomized traffic honouring hold-until-granted
        req = '0; cyc(1);
        pend = '0;
        chk_starve = 1;
        for (int n = 0; n < 500; n++) begin
            for (int i = 0; i < 3; i++) begin
                if (!pend[i] && $urandom_range(0, 1) == 1) begin
                    pend[i] = 1'b1;
                    case (i)
                        0: begin label0 = 4'($urandom_range(0, 15)); data0 = $urandom; end
                        1: begin label1 = 4'($urandom_range(0, 15)); data1 = $urandom; end
                        default: begin label2 = 4'($urandom_range(0, 15)); data2 = $urandom; end
                    endcase
                end
            end
            req = pend;
            cyc(0);
            if (last_g >= 0) pend[last_g] = 1'b0;
        end
        chk_starve = 0;

        // counter wrap: 65536 broadcasts return bc_count to 0
        req = '0; cyc(1);
        req = 3'b001; label0 = 4'h3; data0 = 32'h0000_0042;
        for (int n = 0; n < 65536; n++) cyc(0);
        chk("wrap_cnt", 64'(bc_count), 64'd0);
        chk("wrap_bcen", 64'(BCEN), 64'd1);
        req = '0; cyc(0);
        chk("wrap_idle", 64'(BCEN), 64'd0);

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule

// File: doc/cdb_arbiter.md
CDB_ARBITER -- requirements
Module: cdb_arbiter

Interface
REQ-001 SHALL have parameter DATA_W, default 32, meaning the broadcast data width.
REQ-002 SHALL have parameter LABEL_W, default 4, meaning the tag width; the encoding is {station id + 1, slot}, and 0 means "no tag".
REQ-003 SHALL have port clk, input, 1 bit, the single clock; all state updates on the rising edge.
REQ-004 SHALL have port RST, input, 1 bit, synchronous active-high reset.
REQ-005 SHALL have port req, input, 3 bits, per functional unit (0=ALU, 1=MUL, 2=LOAD): a result is pending.
REQ-006 SHALL have ports label0/label1/label2, input, LABEL_W bits each, the tag of each requester's result.
REQ-007 SHALL have ports data0/data1/data2, input, DATA_W bits each, the value of each requester's result.
REQ-008 SHALL have port gnt, output, 3 bits, one-hot or zero, combinational: the requester's result is accepted this cycle.
REQ-009 SHALL have port BCEN, output, 1 bit, registered broadcast enable to all reservation stations and the register file.
REQ-010 SHALL have port BClabel, output, LABEL_W bits, registered broadcast tag.
REQ-011 SHALL have port BCdata, output, DATA_W bits, registered broadcast value.
REQ-012 SHALL have port tag_err, output, 1 bit, registered one-cycle pulse: a granted request carried label 0.
REQ-013 SHALL have port bc_count, output, 16 bits, registered count of broadcasts issued.

Function
REQ-014 SHALL hold a 2-bit round-robin pointer rr_ptr with legal values 0..2; value 3 is unreachable.
REQ-015 SHALL search requesters starting at rr_ptr in the order rr_ptr, rr_ptr+1, rr_ptr+2 (mod 3), and grant the first one with req high.
REQ-016 SHALL drive gnt as the one-hot grant in the same cycle; gnt is 0 when req==0 or RST is high.
REQ-017 SHALL, on a clock edge where requester i is granted, set rr_ptr to (i+1) mod 3; rr_ptr is unchanged when nothing is granted.
REQ-018 SHALL grant at most one requester per cycle, so that one broadcast per cycle is sustained when requests are continuous.
REQ-019 SHALL, on an edge with grant i and label_i != 0, register BCEN=1, BClabel=label_i and BCdata=data_i, so they are visible exactly one cycle after the grant cycle.
REQ-020 SHALL, on an edge with grant i and label_i == 0, consume the request with gnt high, register BCEN=0 and tag_err=1, and not increment bc_count.
REQ-021 SHALL, on an edge with no grant, register BCEN=0 and tag_err=0; BClabel and BCdata hold their previous values.
REQ-022 SHALL increment bc_count by 1 on each edge that registers BCEN=1, wrapping from 16'hFFFF to 0.
REQ-023 SHALL treat a requester as holding req, label and data stable until the cycle in which its gnt is seen; it may deassert req or present a new result on the following cycle.
REQ-024 SHALL give a requester that stays ungranted for 2 consecutive cycles with req held the grant in the third cycle at the latest (starvation bound of 2).
REQ-025 SHALL let a newly raised req compete in the same cycle it rises, with no extra latency.

Reset
REQ-026 SHALL, on an edge with RST=1, set rr_ptr=0, BCEN=0, BClabel=0, BCdata=0, tag_err=0 and bc_count=0.
REQ-027 SHALL make a grant issued in the cycle RST is asserted ineffective; gnt is forced to 0 during RST, so no broadcast follows.
REQ-028 SHALL need no initial blocks for correct behaviour after the first reset edge.

Verification
REQ-029 SHALL pass a single-requester test: req=3'b001, label0=4'h5, data0=32'hDEAD_BEEF -> gnt=001 in cycle t; BCEN=1, BClabel=5, BCdata=DEADBEEF in t+1; bc_count=1.
REQ-030 SHALL pass a contention test: req=3'b111 held continuously from reset -> grants 001, 010, 100, 001 on consecutive cycles; BCEN=1 every cycle from t+1.
REQ-031 SHALL pass a pointer-skip test: rr_ptr=1 with req=3'b001 -> gnt=001 and rr_ptr becomes 1; then req=3'b011 -> gnt=010.
REQ-032 SHALL pass a zero-tag test: req=3'b100, label2=0 -> gnt=100; next cycle BCEN=0, tag_err=1, bc_count unchanged.
REQ-033 SHALL pass a reset-mid-stream test: req=3'b111 streaming, RST=1 for one cycle -> gnt=0 that cycle; next cycle BCEN=0, bc_count=0; first grant after reset is 001.
REQ-034 SHALL pass a counter-wrap test: force 65536 broadcasts -> bc_count returns to 0 with no glitch on BCEN.
